floppy_track_cache: RTL and testbench
=====================================

# floppy_track_cache

Per-drive track buffer between the IWM floppy controller and the SD block interface. Holds one 6656-byte nibblized track (13 × 512-byte blocks) in internal dual-port RAM, loads it from the disk image whenever the requested track or the mounted disk changes, and writes modified tracks back. One instance per 5.25" drive.

## Interface
Parameters: none. Fixed: 13 blocks per track; buffer size 6656 bytes (0x1A00).
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- ram_addr  in  13  IWM byte address within track
- ram_di  out  8  buffer read data to IWM (registered)
- ram_do  in  8  write data from IWM
- ram_we  in  1  IWM write strobe
- track  in  6  requested track number
- busy  out  1  load/write-back in progress
- change  in  1  toggles on every new mount event
- mount  in  1  image present (size ≠ 0)
- ready  out  1  valid track loaded
- active  in  1  drive motor/selected
- sd_buff_addr  in  9  byte index within current SD block
- sd_buff_dout  in  8  SD read data
- sd_buff_din  out  8  SD write data (registered)
- sd_buff_wr  in  1  SD data write strobe
- sd_lba  out  32  block address
- sd_rd  out  1  block read request
- sd_wr  out  1  block write request
- sd_ack  in  1  SD transfer active

## Operation
- Registers: cur_track (6b + valid bit), blk (4b, 0..12), dirty, last_change, state ∈ {IDLE, REQ, XFER, NEXT}, op ∈ {READ, WRITE}.
- Buffer port A: IWM. Port B: SD, address = blk·512 + sd_buff_addr.
- IDLE priority, evaluated each cycle when not reset:
  1. mount=0: ready=0, valid=0, dirty=0; stay IDLE.
  2. change ≠ last_change: latch last_change, discard dirty, valid=0, ready=0, start READ of track.
  3. dirty and (active=0 or track ≠ cur_track): start WRITE of cur_track.
  4. !valid or track ≠ cur_track: ready=0, start READ of track.
- Start: blk=0, busy=1, state=REQ.
- REQ: sd_lba = cur·13 + blk (cur = track for READ, latched cur_track for WRITE; zero-extended to 32b); assert sd_rd (READ) or sd_wr (WRITE); on sd_ack rising → deassert request, state=XFER.
- XFER: READ: each sd_buff_wr writes sd_buff_dout to buffer. WRITE: sd_buff_din = buffer[blk·512 + sd_buff_addr]. On sd_ack falling → NEXT.
- NEXT: if blk=12: READ → cur_track=track latched at start, valid=1, dirty=0, ready=1; WRITE → dirty=0; busy=0, IDLE. Else blk+1, REQ.
- IWM access: ram_di = buffer[ram_addr] when ram_addr < 0x1A00, else 0xFF. ram_we with ready=1, busy=0, ram_addr < 0x1A00 writes ram_do and sets dirty; otherwise ignored.
- track changing mid-load: current load completes with latched track; IDLE rule 4 then reloads.

## Timing
- Reset values: busy=0, ready=0, sd_rd=0, sd_wr=0, sd_lba=0, ram_di=0, sd_buff_din=0, dirty=0, valid=0, state=IDLE, last_change=change.
- Reset mid-transfer: abort immediately, requests drop next edge, buffer contents retained but invalid.
- ram_di, sd_buff_din: 1-cycle read latency after address.
- sd_rd/sd_wr asserted the cycle after entering REQ; held until sd_ack seen high; sd_lba stable from REQ through XFER.
- ready/busy update in the same cycle as the NEXT→IDLE transition; next request decision one cycle later.
- Simultaneous ram_we and load start: write completes; its dirty is discarded if rule 2 fires.

## Test plan
- Mount (mount=1, toggle change), track=0: sd_rd for LBA 0..12 in order, busy=1 throughout; after 13th ack fall ready=1, busy=0; ram_addr=0x0200 returns byte 0 of block 1.
- track 0→3: READ LBA 39..51; no sd_wr since not dirty.
- ram_we at 0x0005=0xA5, then track→1: WRITE LBA 0..12, sd_buff_din at blk 0 addr 5 = 0xA5, then READ LBA 13..25.
- Dirty track, active 1→0: WRITE LBA cur·13..+12 only, ready stays 1, dirty cleared.
- Dirty track, toggle change: no write-back; fresh READ of current track; written byte replaced by image data.
- mount=0: ready=0, ram_we ignored; ram_addr=0x1A00 reads 0xFF; reset during XFER drops sd_rd/busy next cycle.

Source files
------------

// File: rtl/floppy_track_cache.sv
// Track buffer for one 5.25" drive: caches a 13-block nibblized track between the
// IWM and the SD block interface, loading on track/mount changes and writing back dirty tracks.
module floppy_track_cache (
   input  logic        clk,
   input  logic        reset,
   input  logic [12:0] ram_addr,
   output logic [7:0]  ram_di,
   input  logic [7:0]  ram_do,
   input  logic        ram_we,
   input  logic [5:0]  track,
   output logic        busy,
   input  logic        change,
   input  logic        mount,
   output logic        ready,
   input  logic        active,
   input  logic [8:0]  sd_buff_addr,
   input  logic [7:0]  sd_buff_dout,
   output logic [7:0]  sd_buff_din,
   input  logic        sd_buff_wr,
   output logic [31:0] sd_lba,
   output logic        sd_rd,
   output logic        sd_wr,
   input  logic        sd_ack
);

   localparam logic [12:0] BUF_BYTES = 13'h1A00;
   localparam logic [3:0]  LAST_BLK  = 4'd12;

   typedef enum logic [1:0] {IDLE, REQ, XFER, NEXT} state_t;
   typedef enum logic {OP_READ, OP_WRITE} op_t;

   logic [7:0]  buffer [0:6655];
   logic [5:0]  cur_track;
   logic [5:0]  xfer_track;
   logic        valid;
   logic        dirty;
   logic        last_change;
   logic        ack_prev;
   logic [3:0]  blk;
   state_t      state;
   op_t         op;

   logic [12:0] sd_addr;
   logic        iwm_in_range;
   logic        iwm_write;
   logic        sd_write;
   logic [9:0]  lba_calc;

   assign sd_addr      = {blk, sd_buff_addr};
   assign iwm_in_range = ram_addr < BUF_BYTES;
   assign iwm_write    = !reset && ram_we && ready && !busy && iwm_in_range;
   assign sd_write     = !reset && (state == XFER) && (op == OP_READ) && sd_buff_wr;
   assign lba_calc     = {4'd0, xfer_track} * 10'd13 + {6'd0, blk};

   // Buffer contents survive reset; only the valid flag says whether they mean anything.
   always_ff @(posedge clk) begin
      if (iwm_write)
         buffer[ram_addr] <= ram_do;
      if (sd_write)
         buffer[sd_addr] <= sd_buff_dout;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ram_di      <= 8'h00;
         sd_buff_din <= 8'h00;
      end else begin
         ram_di      <= iwm_in_range ? buffer[ram_addr] : 8'hFF;
         sd_buff_din <= buffer[sd_addr];
      end
   end

   // The dirty set from an IWM write comes first so a same-cycle mount change can discard it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         op          <= OP_READ;
         blk         <= 4'd0;
         busy        <= 1'b0;
         ready       <= 1'b0;
         sd_rd       <= 1'b0;
         sd_wr       <= 1'b0;
         sd_lba      <= 32'd0;
         dirty       <= 1'b0;
         valid       <= 1'b0;
         last_change <= change;
         cur_track   <= 6'd0;
         xfer_track  <= 6'd0;
         ack_prev    <= 1'b0;
      end else begin
         ack_prev <= sd_ack;
         if (iwm_write)
            dirty <= 1'b1;
         case (state)
            IDLE: begin
               if (!mount) begin
                  ready <= 1'b0;
                  valid <= 1'b0;
                  dirty <= 1'b0;
               end else if (change != last_change) begin
                  last_change <= change;
                  dirty       <= 1'b0;
                  valid       <= 1'b0;
                  ready       <= 1'b0;
                  op          <= OP_READ;
                  xfer_track  <= track;
                  blk         <= 4'd0;
                  busy        <= 1'b1;
                  state       <= REQ;
               end else if (dirty && (!active || track != cur_track)) begin
                  op         <= OP_WRITE;
                  xfer_track <= cur_track;
                  blk        <= 4'd0;
                  busy       <= 1'b1;
                  state      <= REQ;
               end else if (!valid || track != cur_track) begin
                  ready      <= 1'b0;
                  op         <= OP_READ;
                  xfer_track <= track;
                  blk        <= 4'd0;
                  busy       <= 1'b1;
                  state      <= REQ;
               end
            end
            REQ: begin
               sd_lba <= {22'd0, lba_calc};
               if (sd_ack && !ack_prev) begin
                  sd_rd <= 1'b0;
                  sd_wr <= 1'b0;
                  state <= XFER;
               end else begin
                  sd_rd <= (op == OP_READ);
                  sd_wr <= (op == OP_WRITE);
               end
            end
            XFER: begin
               if (!sd_ack && ack_prev)
                  state <= NEXT;
            end
            NEXT: begin
               if (blk == LAST_BLK) begin
                  if (op == OP_READ) begin
                     cur_track <= xfer_track;
                     valid     <= 1'b1;
                     ready     <= 1'b1;
                  end
                  dirty <= 1'b0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  blk   <= blk + 4'd1;
                  state <= REQ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_floppy_track_cache.sv
// Directed bench for floppy_track_cache: a small SD block responder feeds a known image
// pattern and every observation is compared against hand-derived values.
module tb_floppy_track_cache;

   logic        clk;
   logic        reset;
   logic [12:0] ram_addr;
   logic [7:0]  ram_di;
   logic [7:0]  ram_do;
   logic        ram_we;
   logic [5:0]  track;
   logic        busy;
   logic        change;
   logic        mount;
   logic        ready;
   logic        active;
   logic [8:0]  sd_buff_addr;
   logic [7:0]  sd_buff_dout;
   logic [7:0]  sd_buff_din;
   logic        sd_buff_wr;
   logic [31:0] sd_lba;
   logic        sd_rd;
   logic        sd_wr;
   logic        sd_ack;

   int compareCount;
   int mismatchCount;

   floppy_track_cache dut (
      .clk          (clk),
      .reset        (reset),
      .ram_addr     (ram_addr),
      .ram_di       (ram_di),
      .ram_do       (ram_do),
      .ram_we       (ram_we),
      .track        (track),
      .busy         (busy),
      .change       (change),
      .mount        (mount),
      .ready        (ready),
      .active       (active),
      .sd_buff_addr (sd_buff_addr),
      .sd_buff_dout (sd_buff_dout),
      .sd_buff_din  (sd_buff_din),
      .sd_buff_wr   (sd_buff_wr),
      .sd_lba       (sd_lba),
      .sd_rd        (sd_rd),
      .sd_wr        (sd_wr),
      .sd_ack       (sd_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [7:0] imgByte(input int lba, input int a);
      return 8'(lba * 17 + a * 3 + 1);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compareCount++;
      if (got !== exp) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [12:0] addr, input logic [7:0] data);
      ram_addr = addr;
      ram_do   = data;
      ram_we   = 1'b1;
      @(negedge clk);
      ram_we   = 1'b0;
   endtask

   task automatic iwmRead(input logic [12:0] addr, output logic [7:0] data);
      ram_addr = addr;
      @(negedge clk);
      data = ram_di;
   endtask

   // One SD block: wait for the request, ack it, move eight bytes, drop ack.
   task automatic serveBlock(input int expLba, input bit expWrite, input string tag,
                             output logic [7:0] byte5, output bit ok);
      ok    = 1'b0;
      byte5 = 8'h00;
      for (int n = 0; n < 50; n++) begin
         if (sd_rd || sd_wr) break;
         @(negedge clk);
      end
      if (!(sd_rd || sd_wr)) begin
         checkOutput({tag, " request timeout"}, 32'd0, 32'd1);
         return;
      end
      checkOutput({tag, " lba"}, sd_lba, 32'(expLba));
      checkOutput({tag, " sd_wr"}, 32'(sd_wr), 32'(expWrite));
      checkOutput({tag, " busy"}, 32'(busy), 32'd1);
      sd_ack = 1'b1;
      @(negedge clk);
      checkOutput({tag, " request dropped"}, 32'(sd_rd | sd_wr), 32'd0);
      for (int i = 0; i < 8; i++) begin
         sd_buff_addr = 9'(i);
         sd_buff_dout = imgByte(expLba, i);
         sd_buff_wr   = !expWrite;
         @(negedge clk);
         if (i == 5) byte5 = sd_buff_din;
      end
      sd_buff_wr = 1'b0;
      sd_ack     = 1'b0;
      @(negedge clk);
      ok = 1'b1;
   endtask

   task automatic loadTrack(input int trk, input bit isWrite, input string tag,
                            output logic [7:0] blk0Byte5);
      logic [7:0] b5;
      bit         ok;
      blk0Byte5 = 8'h00;
      for (int b = 0; b < 13; b++) begin
         if (isWrite) checkOutput($sformatf("%s b%0d ready", tag, b), 32'(ready), 32'd1);
         serveBlock(trk * 13 + b, isWrite, $sformatf("%s b%0d", tag, b), b5, ok);
         if (!ok) return;
         if (b == 0) blk0Byte5 = b5;
      end
      for (int n = 0; n < 20; n++) begin
         if (!busy) break;
         @(negedge clk);
      end
      checkOutput({tag, " busy done"}, 32'(busy), 32'd0);
      checkOutput({tag, " ready done"}, 32'(ready), 32'd1);
   endtask

   task automatic checkQuiet(input string tag, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int n = 0; n < cycles; n++) begin
         @(negedge clk);
         if (sd_rd || sd_wr) seen = 1'b1;
      end
      checkOutput({tag, " no request"}, 32'(seen), 32'd0);
   endtask

   initial begin
      logic [7:0] rd;
      logic [7:0] wb;
      compareCount  = 0;
      mismatchCount = 0;
      reset        = 1'b1;
      ram_addr     = 13'd0;
      ram_do       = 8'h00;
      ram_we       = 1'b0;
      track        = 6'd0;
      change       = 1'b0;
      mount        = 1'b0;
      active       = 1'b1;
      sd_buff_addr = 9'd0;
      sd_buff_dout = 8'h00;
      sd_buff_wr   = 1'b0;
      sd_ack       = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset ready", 32'(ready), 32'd0);
      checkOutput("reset sd_rd", 32'(sd_rd), 32'd0);
      checkOutput("reset sd_wr", 32'(sd_wr), 32'd0);
      checkOutput("reset sd_lba", sd_lba, 32'd0);
      checkOutput("reset ram_di", 32'(ram_di), 32'd0);
      checkOutput("reset sd_buff_din", 32'(sd_buff_din), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] mount, track 0");
      mount  = 1'b1;
      change = 1'b1;
      loadTrack(0, 1'b0, "mount t0", wb);
      checkQuiet("t0 loaded", 8);
      iwmRead(13'h0200, rd);
      checkOutput("t0 blk1 byte0", 32'(rd), 32'h12);
      iwmRead(13'h0005, rd);
      checkOutput("t0 blk0 byte5", 32'(rd), 32'h10);

      $display("[TB] clean switch to track 3");
      track = 6'd3;
      loadTrack(3, 1'b0, "read t3", wb);
      iwmRead(13'h0205, rd);
      checkOutput("t3 blk1 byte5", 32'(rd), 32'(imgByte(40, 5)));

      $display("[TB] dirty track 3, switch to track 1");
      applyStimulus(13'h0005, 8'hA5);
      @(negedge clk);
      checkOutput("t3 write readback", 32'(ram_di), 32'hA5);
      track = 6'd1;
      loadTrack(3, 1'b1, "wb t3", wb);
      checkOutput("wb t3 blk0 byte5", 32'(wb), 32'hA5);
      loadTrack(1, 1'b0, "read t1", wb);
      iwmRead(13'h0005, rd);
      checkOutput("t1 blk0 byte5", 32'(rd), 32'(imgByte(13, 5)));

      $display("[TB] dirty track 1, motor off");
      applyStimulus(13'h0005, 8'h3C);
      active = 1'b0;
      loadTrack(1, 1'b1, "wb t1", wb);
      checkOutput("wb t1 blk0 byte5", 32'(wb), 32'h3C);
      checkQuiet("after wb t1", 20);
      checkOutput("after wb t1 ready", 32'(ready), 32'd1);
      iwmRead(13'h0005, rd);
      checkOutput("after wb t1 byte5", 32'(rd), 32'h3C);

      $display("[TB] dirty track 1, remount");
      active = 1'b1;
      applyStimulus(13'h0005, 8'h77);
      change = 1'b0;
      loadTrack(1, 1'b0, "remount t1", wb);
      iwmRead(13'h0005, rd);
      checkOutput("remount byte5", 32'(rd), 32'(imgByte(13, 5)));

      $display("[TB] reset during transfer, then unmounted");
      track = 6'd2;
      for (int n = 0; n < 20; n++) begin
         if (sd_rd) break;
         @(negedge clk);
      end
      checkOutput("t2 sd_rd raised", 32'(sd_rd), 32'd1);
      sd_ack = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      mount = 1'b0;
      @(negedge clk);
      checkOutput("xfer reset busy", 32'(busy), 32'd0);
      checkOutput("xfer reset sd_rd", 32'(sd_rd), 32'd0);
      checkOutput("xfer reset ready", 32'(ready), 32'd0);
      checkOutput("xfer reset sd_lba", sd_lba, 32'd0);
      sd_ack = 1'b0;
      reset  = 1'b0;
      checkQuiet("unmounted", 10);
      checkOutput("unmounted ready", 32'(ready), 32'd0);
      applyStimulus(13'h0005, 8'h99);
      @(negedge clk);
      checkOutput("unmounted we ignored", 32'(ram_di), 32'(imgByte(13, 5)));
      iwmRead(13'h1A00, rd);
      checkOutput("out of range read", 32'(rd), 32'hFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
